// File: rtl/nn_pkg.sv
// Shared types and defaults for the generated network and its drivers.
// Layer generators and the driver take their default widths from here.
package nn_pkg;

    localparam int DEF_DW = 8;
    localparam int DEF_OW = 10;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        SETTLE,
        OUT
    } nn_drv_state_t;

endpackage

// File: rtl/nn_wdog.sv
// Wait-cycle counter for the layer driver.
// Flags expiry once TIMEOUT-1 enabled cycles have elapsed since the last clear.
module nn_wdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/nn_layer_driver.sv
// Start/done initiator for the first layer of a generated network: accepts one
// sample, runs the layer once under a watchdog, and returns its output vector.
module nn_layer_driver
    import nn_pkg::*;
#(
    parameter int N_IN    = 1,
    parameter int N_OUT   = 4,
    parameter int DW      = DEF_DW,
    parameter int OW      = DEF_OW,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N_IN*DW-1:0]  in_data,
    output logic                l_start,
    input  logic                l_done,
    output logic [N_IN*DW-1:0]  l_in,
    input  logic [N_OUT*OW-1:0] l_out,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [N_OUT*OW-1:0] res_data,
    output logic                busy,
    output logic                timeout_err
);

    // Both streams transfer on a rising edge where valid && ready. A producer
    // never drops valid or changes data until that transfer; ready may move freely.

    nn_drv_state_t       state;
    logic [N_IN*DW-1:0]  in_reg;
    logic                wdog_expired;

    nn_wdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == START),
        .enable (state == WAIT),
        .expired(wdog_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_reg      <= '0;
            l_start     <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            timeout_err <= 1'b0;
        end else begin
            l_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_reg      <= in_data;
                        timeout_err <= 1'b0;
                        l_start     <= 1'b1;
                        state       <= START;
                    end
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the final allowed cycle still counts.
                    if (l_done) begin
                        state <= SETTLE;
                    end else if (wdog_expired) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end
                end
                SETTLE: begin
                    // The layer's output register updates on the done edge, so sample one cycle later.
                    res_data  <= l_out;
                    res_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign l_in     = in_reg;
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_nn_layer_driver.sv
// Bench for nn_layer_driver: two instances (long and short watchdog) share stimulus;
// a select picks which one the current test observes.
module tb_nn_layer_driver;

    localparam int N_IN  = 1;
    localparam int N_OUT = 4;
    localparam int DW    = 8;
    localparam int OW    = 10;
    localparam int TO_A  = 64;
    localparam int TO_B  = 8;
    localparam int RW    = N_OUT * OW;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                l_done = 1'b0;
    logic                res_ready = 1'b0;
    logic                sel = 1'b0;
    logic [N_IN*DW-1:0]  in_data = '0;
    logic [RW-1:0]       l_out = '0;

    logic                a_in_ready, a_l_start, a_res_valid, a_busy, a_timeout_err;
    logic [N_IN*DW-1:0]  a_l_in;
    logic [RW-1:0]       a_res_data;
    logic                b_in_ready, b_l_start, b_res_valid, b_busy, b_timeout_err;
    logic [N_IN*DW-1:0]  b_l_in;
    logic [RW-1:0]       b_res_data;

    logic                s_in_ready, s_l_start, s_res_valid, s_busy, s_timeout_err;
    logic [N_IN*DW-1:0]  s_l_in;
    logic [RW-1:0]       s_res_data;

    nn_layer_driver #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .OW(OW), .TIMEOUT(TO_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .l_start(a_l_start), .l_done(l_done), .l_in(a_l_in),
        .l_out(l_out), .res_valid(a_res_valid), .res_ready(res_ready),
        .res_data(a_res_data), .busy(a_busy), .timeout_err(a_timeout_err)
    );

    nn_layer_driver #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .OW(OW), .TIMEOUT(TO_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .l_start(b_l_start), .l_done(l_done), .l_in(b_l_in),
        .l_out(l_out), .res_valid(b_res_valid), .res_ready(res_ready),
        .res_data(b_res_data), .busy(b_busy), .timeout_err(b_timeout_err)
    );

    always_comb begin
        s_in_ready    = sel ? b_in_ready    : a_in_ready;
        s_l_start     = sel ? b_l_start     : a_l_start;
        s_res_valid   = sel ? b_res_valid   : a_res_valid;
        s_busy        = sel ? b_busy        : a_busy;
        s_timeout_err = sel ? b_timeout_err : a_timeout_err;
        s_l_in        = sel ? b_l_in        : a_l_in;
        s_res_data    = sel ? b_res_data    : a_res_data;
    end

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: got no $finish, expected completion");
        $fatal(1, "bench timed out");
    end

    typedef struct {
        logic [DW-1:0] din;
        int            dly;
        int            hold;
        logic [RW-1:0] lo;
        logic [RW-1:0] exp_res;
    } vec_t;

    vec_t          vecs[5];
    logic [RW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // All driver tasks start and end just after a falling edge.
    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        l_done = 1'b0;
        res_ready = 1'b0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic run_txn(input vec_t v);
        int bad_start = 0;
        int early = 0;
        int stall_bad = 0;
        logic [RW-1:0] want;
        in_data = v.din;
        in_valid = 1'b1;
        check("in_ready_idle", 64'(s_in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("l_start_pulse", 64'(s_l_start), 64'd1);
        check("l_in_latched", 64'(s_l_in), 64'(v.din));
        @(negedge clk);
        if (s_l_start) bad_start++;
        repeat (v.dly - 1) begin
            @(negedge clk);
            if (s_l_start) bad_start++;
            if (s_res_valid) early++;
        end
        l_done = 1'b1;
        l_out = v.lo;
        exp_q.push_back(v.exp_res);
        @(negedge clk);
        l_done = 1'b0;
        check("res_valid_low_at_done", 64'(s_res_valid), 64'd0);
        check("no_early_res_valid", 64'(early), 64'd0);
        @(negedge clk);
        l_out = ~v.lo;
        check("res_valid_rise", 64'(s_res_valid), 64'd1);
        repeat (v.hold) begin
            in_valid = 1'b1;
            in_data = ~v.din;
            @(negedge clk);
            if (s_l_start) bad_start++;
            if (!s_res_valid || s_res_data !== v.exp_res || s_in_ready) stall_bad++;
        end
        if (v.hold > 0) check("backpressure_stable", 64'(stall_bad), 64'd0);
        in_valid = 1'b0;
        res_ready = 1'b1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got result %0h expected nothing queued", s_res_data);
        end else begin
            want = exp_q.pop_front();
            check("res_data", 64'(s_res_data), 64'(want));
        end
        check("l_in_stable", 64'(s_l_in), 64'(v.din));
        @(negedge clk);
        res_ready = 1'b0;
        check("idle_after_handshake", 64'({s_in_ready, s_res_valid, s_busy, s_timeout_err}), 64'b1000);
        check("single_l_start", 64'(bad_start), 64'd0);
    endtask

    initial begin
        logic [63:0] r64;
        int bad;
        vec_t race;

        vecs[0] = '{din: 8'h05, dly: 16, hold: 0,
                    lo: {10'd3, 10'd2, 10'd1, 10'd0}, exp_res: {10'd3, 10'd2, 10'd1, 10'd0}};
        vecs[1] = '{din: 8'hA5, dly: 3, hold: 10,
                    lo: {10'h3FF, 10'h000, 10'h2AA, 10'h155}, exp_res: {10'h3FF, 10'h000, 10'h2AA, 10'h155}};
        vecs[2] = '{din: 8'hFF, dly: 1, hold: 0,
                    lo: {10'h200, 10'h001, 10'h3FE, 10'h100}, exp_res: {10'h200, 10'h001, 10'h3FE, 10'h100}};
        for (int i = 3; i < 5; i++) begin
            r64 = {$urandom(), $urandom()};
            vecs[i].din     = 8'($urandom_range(0, 255));
            vecs[i].dly     = $urandom_range(1, 40);
            vecs[i].hold    = $urandom_range(0, 4);
            vecs[i].lo      = r64[RW-1:0];
            vecs[i].exp_res = r64[RW-1:0];
        end

        // reset then idle
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_a_outputs", 64'({a_in_ready, a_l_start, a_res_valid, a_busy, a_timeout_err}), 64'b10000);
        check("reset_a_l_in", 64'(a_l_in), 64'd0);
        check("reset_a_res_data", 64'(a_res_data), 64'd0);
        check("reset_b_outputs", 64'({b_in_ready, b_l_start, b_res_valid, b_busy, b_timeout_err}), 64'b10000);

        // table-driven runs on the long-watchdog instance
        sel = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_reset(1);
            run_txn(vecs[i]);
        end

        // timeout on the short-watchdog instance
        sel = 1'b1;
        do_reset(2);
        in_data = 8'h3C;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        bad = 0;
        for (int c = 1; c <= TO_B + 1; c++) begin
            @(negedge clk);
            if (c <= TO_B && (s_in_ready || s_timeout_err)) bad++;
            if (s_res_valid) bad++;
        end
        check("timeout_not_early", 64'(bad), 64'd0);
        check("timeout_err_set", 64'(s_timeout_err), 64'd1);
        check("timeout_in_ready", 64'(s_in_ready), 64'd1);
        check("timeout_busy_low", 64'(s_busy), 64'd0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("timeout_err_cleared", 64'(s_timeout_err), 64'd0);
        check("restart_l_start", 64'(s_l_start), 64'd1);

        // done coinciding with the last wait cycle
        do_reset(1);
        race = '{din: 8'h6E, dly: TO_B, hold: 2,
                 lo: {10'h111, 10'h222, 10'h333, 10'h0F0}, exp_res: {10'h111, 10'h222, 10'h333, 10'h0F0}};
        run_txn(race);

        // reset while waiting
        sel = 1'b0;
        do_reset(1);
        in_data = 8'h42;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("wait_reset_idle", 64'({s_in_ready, s_res_valid, s_busy}), 64'b100);
        check("wait_reset_l_in", 64'(s_l_in), 64'd0);
        rst_n = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (s_l_start || s_busy) bad++;
        end
        check("wait_reset_quiet", 64'(bad), 64'd0);

        // reset while holding a result
        in_data = 8'h99;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        l_done = 1'b1;
        l_out = {10'h0AB, 10'h0CD, 10'h0EF, 10'h012};
        @(negedge clk);
        l_done = 1'b0;
        @(negedge clk);
        check("out_reached", 64'(s_res_valid), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("out_reset_res_valid", 64'(s_res_valid), 64'd0);
        check("out_reset_res_data", 64'(s_res_data), 64'd0);
        check("out_reset_in_ready", 64'(s_in_ready), 64'd1);
        rst_n = 1'b1;
        exp_q.delete();
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (s_l_start || s_res_valid || s_busy) bad++;
        end
        check("out_reset_quiet", 64'(bad), 64'd0);

        // stray done while idle
        l_done = 1'b1;
        l_out = {10'h3AA, 10'h155, 10'h0FF, 10'h300};
        @(negedge clk);
        l_done = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (s_l_start || s_res_valid || s_busy || !s_in_ready) bad++;
        end
        check("idle_done_ignored", 64'(bad), 64'd0);
        check("idle_done_res_data", 64'(s_res_data), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
